// File: rtl/adder_pkg.sv
// Shared types and segmentation helpers for the pipelined adder.
//   seg_width : bits per carry-chain segment, ceil(width/stages)
//   seg_lo    : lowest bit handled by segment k (clamped to width)
//   seg_len   : bits handled by segment k; 0 for trailing segments left empty
//   stage_ctl_t : per-stage valid flag and registered inter-stage carry
package adder_pkg;

    localparam int unsigned MAX_WIDTH = 64;

    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    function automatic int unsigned seg_width(input int unsigned width,
                                              input int unsigned stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic int unsigned seg_lo(input int unsigned width,
                                           input int unsigned stages,
                                           input int unsigned k);
        int unsigned lo;
        lo = k * seg_width(width, stages);
        return (lo > width) ? width : lo;
    endfunction

    function automatic int unsigned seg_len(input int unsigned width,
                                            input int unsigned stages,
                                            input int unsigned k);
        int unsigned lo;
        int unsigned hi;
        lo = seg_lo(width, stages, k);
        hi = lo + seg_width(width, stages);
        if (hi > width) hi = width;
        return hi - lo;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple segment: {cout_o, sum_o} = a_i + b_i + cin_i.
// Ports:
//   a_i, b_i  W-bit operand segments
//   cin_i     carry into the segment
//   sum_o     W-bit segment sum
//   cout_o    carry out of the segment's top bit
module adder_slice #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    assign {cout_o, sum_o} = (W+1)'(a_i) + (W+1)'(b_i) + (W+1)'(cin_i);

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder with valid/ready handshake.
// The WIDTH-bit carry chain is cut into STAGES segments; each stage adds one
// segment and registers its partial sum, the carry into the next segment and
// the still-unprocessed operand bits. Latency STAGES, throughput 1/cycle.
// Optional build macro ADDER_SUB_EN adds a 'sub' input (a + ~b + 1, cin ignored).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    input handshake (in_ready = pipeline may advance)
//   a, b, cin              operands and carry-in
//   sub                    subtract select (ADDER_SUB_EN only)
//   out_valid / out_ready  output handshake
//   sum, cout              (a + b + cin) mod 2^WIDTH and carry out of bit WIDTH-1
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Per-stage registers and the combinational inputs feeding each stage
    logic [WIDTH-1:0] a_q    [STAGES];
    logic [WIDTH-1:0] b_q    [STAGES];
    logic [WIDTH-1:0] s_q    [STAGES];
    stage_ctl_t       ctl_q  [STAGES];
    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] s_in   [STAGES];
    stage_ctl_t       ctl_in [STAGES];
    logic [WIDTH-1:0] s_d    [STAGES];
    stage_ctl_t       ctl_d  [STAGES];

    // Subtraction is folded in at the entry so it travels with its operands
`ifdef ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    // Whole pipeline moves together unless a held result blocks the output
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage 0 is fed from the ports, every later stage from its predecessor
    always_comb begin
        a_in[0]   = a;
        b_in[0]   = b_eff;
        s_in[0]   = '0;
        ctl_in[0] = '{valid: in_valid, carry: cin_eff};
        for (int k = 1; k < STAGES; k++) begin
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            s_in[k]   = s_q[k-1];
            ctl_in[k] = ctl_q[k-1];
        end
    end

    // One segment adder per stage; trailing empty segments just pass through
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO  = seg_lo(WIDTH, STAGES, k);
        localparam int unsigned LEN = seg_len(WIDTH, STAGES, k);

        if (LEN > 0) begin : g_add
            logic [LEN-1:0] seg_sum;
            logic           seg_cout;

            adder_slice #(
                .W(LEN)
            ) u_slice (
                .a_i   (LEN'(a_in[k] >> LO)),
                .b_i   (LEN'(b_in[k] >> LO)),
                .cin_i (ctl_in[k].carry),
                .sum_o (seg_sum),
                .cout_o(seg_cout)
            );

            // Bits at and above LO are still zero in the partial sum
            assign s_d[k]   = s_in[k] | (WIDTH'(seg_sum) << LO);
            assign ctl_d[k] = '{valid: ctl_in[k].valid, carry: seg_cout};
        end else begin : g_pass
            assign s_d[k]   = s_in[k];
            assign ctl_d[k] = ctl_in[k];
        end
    end

    // Pipeline registers: cleared on reset, frozen while the output stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                ctl_q[k] <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_in[k];
                b_q[k]   <= b_in[k];
                s_q[k]   <= s_d[k];
                ctl_q[k] <= ctl_d[k];
            end
        end
    end

    assign out_valid = ctl_q[STAGES-1].valid;
    assign sum       = s_q[STAGES-1];
    assign cout      = ctl_q[STAGES-1].carry;

endmodule
